warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
Per-core warp scheduler that interleaves up to NUM_WARPS independent warps onto the shared fetch/decode/execute pipeline of one compute core. It tracks each warp's PC and lifecycle state and picks the next ready warp round-robin. It issues that warp to the pipeline over a valid/ready handshake. It parks warps that retire on a memory access until the LSUs report completion, and raises done once every launched warp has executed RET.

Parameters:
NUM_WARPS, 4, warps resident per core (power of two, >=2)
PC_BITS, 8, program counter width
WID_BITS, $clog2(NUM_WARPS), warp id width (derived, not overridable)

Ports:
clk  input  1  core clock, all state changes on rising edge
reset  input  1  synchronous reset, active-low (reset==0 resets on the next clk edge)
start  input  1  launch block; sampled only while scheduler is IDLE
warp_count  input  WID_BITS+1  number of warps launched (0..NUM_WARPS), sampled with start
issue_valid  output  1  issue_warp_id/issue_pc hold a candidate
issue_ready  input  1  pipeline accepts candidate this cycle
issue_warp_id  output  WID_BITS  warp being issued
issue_pc  output  PC_BITS  PC of issued warp
retire_valid  input  1  pipeline finished UPDATE for a warp
retire_warp_id  input  WID_BITS  retiring warp
retire_next_pc  input  PC_BITS  PC to resume at
retire_ret  input  1  retiring instruction was RET
retire_mem_wait  input  1  retiring warp must wait for outstanding LSU traffic
mem_done_valid  input  1  LSUs finished for a warp
mem_done_warp_id  input  WID_BITS  warp whose memory traffic completed
done  output  1  all launched warps finished
protocol_err  output  1  sticky: retire/mem_done for a warp in the wrong state

Behaviour:
- Per-warp state: W_IDLE, W_READY, W_ISSUED, W_STALLED, W_DONE; per-warp pc[PC_BITS]; round-robin pointer rr_ptr.
- Reset: all warps W_IDLE, all pc=0, rr_ptr=0, issue_valid=0, issue_warp_id=0, issue_pc=0, done=0, protocol_err=0. Reset mid-operation abandons all warps; the pipeline is reset by the same signal.
- Launch: start=1 while all warps W_IDLE → warps with index < warp_count go W_READY with pc=0; the rest go W_DONE. start is ignored at all other times. warp_count > NUM_WARPS is clamped to NUM_WARPS.
- Selection: when issue_valid==0, pick the first W_READY warp scanning rr_ptr, rr_ptr+1, ... mod NUM_WARPS. Register issue_valid=1, issue_warp_id and issue_pc. If no warp is ready, issue_valid stays 0.
- Latency: a warp that becomes W_READY at edge t can appear on issue_valid at edge t+1 at the earliest.
- Handshake: while issue_valid=1 and issue_ready=0, issue_warp_id and issue_pc are held stable.
- On issue_valid&&issue_ready: the warp goes W_ISSUED, rr_ptr = issue_warp_id+1 (wraps), and issue_valid=0 next cycle. This gives one bubble cycle between issues. Several warps may be W_ISSUED concurrently.
- Retire (retire_valid, warp in W_ISSUED), priority order:
  - retire_ret → W_DONE.
  - else retire_mem_wait → W_STALLED, pc=retire_next_pc.
  - else → W_READY, pc=retire_next_pc.
- Retire for a warp not in W_ISSUED: ignored, protocol_err=1.
- mem_done_valid for a W_STALLED warp → W_READY. For a warp in any other state: ignored, protocol_err=1.
- Simultaneous events: retire, mem_done and issue-accept in one cycle all apply, each to its own warp. If retire and mem_done name the same warp, retire applies and protocol_err is set.
- done: set the cycle after all warps reach W_DONE following a launch, including warp_count=0. Once set, done holds until reset. issue_valid stays 0 while done=1.

Decomposition:
- Package gpu_sched_pkg holds:
  - warp_state_t enum (3 bits: W_IDLE=0, W_READY=1, W_ISSUED=2, W_STALLED=3, W_DONE=4)
  - retire-cause constants
- One sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: ready mask[NUM_WARPS], rr_ptr.
  - Outputs: found and warp id.

Test Plan:
1. Round-robin: warp_count=3, start=1, issue_ready=1; retire each issued warp 2 cycles later with next_pc=pc+1 → issue order 0,1,2,0,1,2 with pc 0,0,0,1,1,1; warp 3 never issued.
2. Memory stall: warp_count=2; warp0 retires with retire_mem_wait=1, next_pc=5 → only warp1 issued until mem_done_valid for warp0. Warp0 then reissued with issue_pc=5 no earlier than 2 cycles after mem_done.
3. Backpressure: issue_valid=1 with issue_ready=0 for 10 cycles → issue_warp_id and issue_pc unchanged. Acceptance on cycle 11 → issue_valid=0 on cycle 12.
4. Completion: warp_count=4, every warp retires with retire_ret=1 → done=1 exactly one cycle after the last retire. done holds; a further start is ignored.
5. Edge cases:
   - warp_count=0 → done=1 one cycle after the launch edge, with no issue.
   - retire for a W_READY warp → protocol_err=1 and the warp state is unchanged.
6. Reset mid-run: reset=0 for one edge while warps are W_ISSUED/W_STALLED → all outputs return to reset values. A new start with warp_count=1 → issues warp0 at pc=0.

Source files
------------

// File: rtl/gpu_sched_pkg.sv
// rtl/gpu_sched_pkg.sv - shared warp scheduler types and retire-cause decoding
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_READY   = 3'd1,
    W_ISSUED  = 3'd2,
    W_STALLED = 3'd3,
    W_DONE    = 3'd4
  } warp_state_t;

  typedef enum logic [1:0] {
    RC_NEXT = 2'd0,
    RC_MEM  = 2'd1,
    RC_RET  = 2'd2
  } retire_cause_t;

  // RET outranks a memory wait: a returning warp never needs to be woken again
  function automatic retire_cause_t retire_cause(input logic ret, input logic mem_wait);
    if (ret) return RC_RET;
    if (mem_wait) return RC_MEM;
    return RC_NEXT;
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// rtl/warp_scheduler_rr_picker.sv - combinational round-robin pick of the first ready warp at or after rr_ptr
module rr_picker #(
  parameter int NUM_WARPS = 4,
  localparam int WID_BITS = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] ready_mask,
  input  logic [WID_BITS-1:0]  rr_ptr,
  output logic                 found,
  output logic [WID_BITS-1:0]  warp_id
);

  logic [WID_BITS-1:0] idx;

  // Scan farthest-first so the nearest ready warp is the last write
  always_comb begin
    found   = 1'b0;
    warp_id = '0;
    idx     = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      idx = rr_ptr + WID_BITS'(i);
      if (ready_mask[idx]) begin
        found   = 1'b1;
        warp_id = idx;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-core warp lifecycle tracking, round-robin issue, memory stall and completion
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int PC_BITS   = 8,
  localparam int WID_BITS = $clog2(NUM_WARPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WID_BITS:0]   warp_count,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [WID_BITS-1:0] issue_warp_id,
  output logic [PC_BITS-1:0]  issue_pc,
  input  logic                retire_valid,
  input  logic [WID_BITS-1:0] retire_warp_id,
  input  logic [PC_BITS-1:0]  retire_next_pc,
  input  logic                retire_ret,
  input  logic                retire_mem_wait,
  input  logic                mem_done_valid,
  input  logic [WID_BITS-1:0] mem_done_warp_id,
  output logic                done,
  output logic                protocol_err
);

  warp_state_t         state_q [NUM_WARPS];
  warp_state_t         state_d [NUM_WARPS];
  logic [PC_BITS-1:0]  pc_q    [NUM_WARPS];
  logic [PC_BITS-1:0]  pc_d    [NUM_WARPS];
  logic [WID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                issue_valid_q, issue_valid_d;
  logic [WID_BITS-1:0] issue_warp_id_q, issue_warp_id_d;
  logic [PC_BITS-1:0]  issue_pc_q, issue_pc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [NUM_WARPS-1:0] ready_mask;
  logic                 all_idle, all_done;
  logic [WID_BITS:0]    launch_count;
  logic                 pick_found;
  logic [WID_BITS-1:0]  pick_id;

  always_comb begin
    ready_mask = '0;
    all_idle   = 1'b1;
    all_done   = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_mask[i] = (state_q[i] == W_READY);
      all_idle      = all_idle && (state_q[i] == W_IDLE);
      all_done      = all_done && (state_q[i] == W_DONE);
    end
  end

  assign launch_count = (warp_count > (WID_BITS+1)'(NUM_WARPS)) ? (WID_BITS+1)'(NUM_WARPS) : warp_count;

  rr_picker #(.NUM_WARPS(NUM_WARPS)) u_picker (
    .ready_mask (ready_mask),
    .rr_ptr     (rr_ptr_q),
    .found      (pick_found),
    .warp_id    (pick_id)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    rr_ptr_d        = rr_ptr_q;
    issue_valid_d   = issue_valid_q;
    issue_warp_id_d = issue_warp_id_q;
    issue_pc_d      = issue_pc_q;
    err_d           = err_q;
    done_d          = done_q || all_done;

    if (start && all_idle) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_d[i] = ((WID_BITS+1)'(i) < launch_count) ? W_READY : W_DONE;
        pc_d[i]    = '0;
      end
    end

    // Selection only when the slot is empty, giving one bubble after every accept
    if (issue_valid_q && issue_ready) begin
      state_d[issue_warp_id_q] = W_ISSUED;
      rr_ptr_d                 = issue_warp_id_q + WID_BITS'(1);
      issue_valid_d            = 1'b0;
    end else if (!issue_valid_q && !done_q && pick_found) begin
      issue_valid_d   = 1'b1;
      issue_warp_id_d = pick_id;
      issue_pc_d      = pc_q[pick_id];
    end

    if (retire_valid) begin
      if (state_q[retire_warp_id] == W_ISSUED) begin
        case (retire_cause(retire_ret, retire_mem_wait))
          RC_RET: state_d[retire_warp_id] = W_DONE;
          RC_MEM: begin
            state_d[retire_warp_id] = W_STALLED;
            pc_d[retire_warp_id]    = retire_next_pc;
          end
          default: begin
            state_d[retire_warp_id] = W_READY;
            pc_d[retire_warp_id]    = retire_next_pc;
          end
        endcase
      end else begin
        err_d = 1'b1;
      end
    end

    if (mem_done_valid) begin
      if (retire_valid && (retire_warp_id == mem_done_warp_id)) begin
        err_d = 1'b1;
      end else if (state_q[mem_done_warp_id] == W_STALLED) begin
        state_d[mem_done_warp_id] = W_READY;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= W_IDLE;
        pc_q[i]    <= '0;
      end
      rr_ptr_q        <= '0;
      issue_valid_q   <= 1'b0;
      issue_warp_id_q <= '0;
      issue_pc_q      <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      rr_ptr_q        <= rr_ptr_d;
      issue_valid_q   <= issue_valid_d;
      issue_warp_id_q <= issue_warp_id_d;
      issue_pc_q      <= issue_pc_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign issue_valid   = issue_valid_q;
  assign issue_warp_id = issue_warp_id_q;
  assign issue_pc      = issue_pc_q;
  assign done          = done_q;
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - directed stimulus with a warp-level reference model checked every cycle
module tb_warp_scheduler;

  localparam int N = 4;
  localparam int S_IDLE = 0, S_READY = 1, S_ISSUED = 2, S_STALL = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] warp_count = '0;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [1:0] issue_warp_id;
  logic [7:0] issue_pc;
  logic       retire_valid = 1'b0;
  logic [1:0] retire_warp_id = '0;
  logic [7:0] retire_next_pc = '0;
  logic       retire_ret = 1'b0;
  logic       retire_mem_wait = 1'b0;
  logic       mem_done_valid = 1'b0;
  logic [1:0] mem_done_warp_id = '0;
  logic       done;
  logic       protocol_err;

  warp_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .warp_count       (warp_count),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_warp_id    (issue_warp_id),
    .issue_pc         (issue_pc),
    .retire_valid     (retire_valid),
    .retire_warp_id   (retire_warp_id),
    .retire_next_pc   (retire_next_pc),
    .retire_ret       (retire_ret),
    .retire_mem_wait  (retire_mem_wait),
    .mem_done_valid   (mem_done_valid),
    .mem_done_warp_id (mem_done_warp_id),
    .done             (done),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: warp lifecycle by spec rules
  int  m_st [N];
  int  m_pc [N];
  int  n_st [N];
  int  n_pc [N];
  int  m_rr, m_iw, m_ipc;
  bit  m_iv, m_done, m_err;
  int  n_rr, n_iw, n_ipc;
  bit  n_iv, n_err;
  int  cyc = 0;

  typedef struct {int w; int pc; int due;} pend_t;
  pend_t pending[$];
  int    acc_w[$];
  int    acc_pc[$];
  int    acc_cyc[$];
  int    auto_mode = 0;  // 0 none, 1 next_pc=pc+1, 2 RET
  bit    mw_armed = 0;
  int    mw_warp = 0, mw_pc = 0;
  int    stall_edge = -1, last_edge = -1, ret_cnt = 0;

  always @(posedge clk) begin
    bit idle_all, done_all, picked;
    int cnt, w;
    cyc++;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin m_st[i] = S_IDLE; m_pc[i] = 0; end
      m_rr = 0; m_iv = 0; m_iw = 0; m_ipc = 0; m_done = 0; m_err = 0;
      pending.delete();
    end else begin
      n_st = m_st; n_pc = m_pc; n_rr = m_rr; n_iv = m_iv; n_iw = m_iw; n_ipc = m_ipc; n_err = m_err;
      idle_all = 1; done_all = 1;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] != S_IDLE) idle_all = 0;
        if (m_st[i] != S_DONE) done_all = 0;
      end
      if (start && idle_all) begin
        cnt = (int'(warp_count) > N) ? N : int'(warp_count);
        for (int i = 0; i < N; i++) begin n_st[i] = (i < cnt) ? S_READY : S_DONE; n_pc[i] = 0; end
      end
      if (m_iv && issue_ready) begin
        n_st[m_iw] = S_ISSUED; n_rr = (m_iw + 1) % N; n_iv = 0;
        acc_w.push_back(m_iw); acc_pc.push_back(m_ipc); acc_cyc.push_back(cyc);
        if (auto_mode != 0) pending.push_back('{m_iw, m_ipc, cyc + 2});
      end else if (!m_iv && !m_done) begin
        picked = 0;
        for (int k = 0; k < N; k++) begin
          w = (m_rr + k) % N;
          if (!picked && m_st[w] == S_READY) begin picked = 1; n_iv = 1; n_iw = w; n_ipc = m_pc[w]; end
        end
      end
      if (retire_valid) begin
        if (m_st[retire_warp_id] != S_ISSUED) n_err = 1;
        else if (retire_ret) n_st[retire_warp_id] = S_DONE;
        else begin
          n_st[retire_warp_id] = retire_mem_wait ? S_STALL : S_READY;
          n_pc[retire_warp_id] = int'(retire_next_pc);
        end
      end
      if (mem_done_valid) begin
        if (retire_valid && retire_warp_id == mem_done_warp_id) n_err = 1;
        else if (m_st[mem_done_warp_id] == S_STALL) n_st[mem_done_warp_id] = S_READY;
        else n_err = 1;
      end
      m_done = m_done || done_all;
      m_st = n_st; m_pc = n_pc; m_rr = n_rr; m_iv = n_iv; m_iw = n_iw; m_ipc = n_ipc; m_err = n_err;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issue_valid", issue_valid, m_iv);
      chk("done", done, m_done);
      chk("protocol_err", protocol_err, m_err);
      if (m_iv) begin
        chk("issue_warp_id", issue_warp_id, m_iw);
        chk("issue_pc", issue_pc, m_ipc);
      end
    end
  end

  task automatic step();
    pend_t p;
    @(posedge clk); #1;
    start = 0; retire_valid = 0; retire_ret = 0; retire_mem_wait = 0; mem_done_valid = 0;
    if (pending.size() > 0 && pending[0].due == cyc + 1) begin
      p = pending.pop_front();
      retire_valid = 1;
      retire_warp_id = 2'(p.w);
      if (auto_mode == 2) retire_ret = 1;
      else if (mw_armed && p.w == mw_warp) begin
        retire_mem_wait = 1; retire_next_pc = 8'(mw_pc); mw_armed = 0; stall_edge = cyc + 1;
      end else retire_next_pc = 8'(p.pc + 1);
      ret_cnt++;
      last_edge = cyc + 1;
    end
  endtask

  task automatic do_reset();
    reset = 0; issue_ready = 0; auto_mode = 0; mw_armed = 0;
    step(); chk_en = 1; step();
    reset = 1;
    acc_w.delete(); acc_pc.delete(); acc_cyc.delete();
    stall_edge = -1; last_edge = -1; ret_cnt = 0;
  endtask

  task automatic launch(input int count);
    warp_count = 3'(count); start = 1; step();
  endtask

  task automatic wait_acc(input int n, input int bound, input string name);
    int g = 0;
    while (acc_w.size() < n && g < bound) begin step(); g++; end
    chk({name, "_timeout"}, acc_w.size() >= n, 1);
  endtask

  initial begin
    int n0, g, md_edge, idx;
    int exp_w[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_pc[6] = '{0, 0, 0, 1, 1, 1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_warp_id", issue_warp_id, 0);
    chk("rst_issue_pc", issue_pc, 0);
    chk("rst_done", done, 0);
    chk("rst_err", protocol_err, 0);

    // Round-robin over three warps
    auto_mode = 1; issue_ready = 1;
    launch(3);
    wait_acc(6, 60, "rr");
    for (int i = 0; i < 6; i++) begin
      if (i < acc_w.size()) begin
        chk("rr_order_w", acc_w[i], exp_w[i]);
        chk("rr_order_pc", acc_pc[i], exp_pc[i]);
      end
    end

    // Memory stall of warp0
    do_reset();
    auto_mode = 1; issue_ready = 1; mw_armed = 1; mw_warp = 0; mw_pc = 5;
    launch(2);
    g = 0;
    while (stall_edge < 0 && g < 30) begin step(); g++; end
    chk("stall_seen", stall_edge >= 0, 1);
    n0 = acc_w.size();
    repeat (10) step();
    chk("stall_w1_progress", (acc_w.size() - n0) >= 2, 1);
    for (int i = n0; i < acc_w.size(); i++) chk("stall_only_w1", acc_w[i], 1);
    mem_done_valid = 1; mem_done_warp_id = 0; md_edge = cyc + 1;
    n0 = acc_w.size();
    step();
    g = 0; idx = -1;
    while (idx < 0 && g < 20) begin
      for (int i = n0; i < acc_w.size(); i++) if (idx < 0 && acc_w[i] == 0) idx = i;
      if (idx < 0) begin step(); g++; end
    end
    chk("wake_seen", idx >= 0, 1);
    if (idx >= 0) begin
      chk("wake_pc", acc_pc[idx], 5);
      chk("wake_latency", (acc_cyc[idx] - md_edge) >= 2, 1);
    end

    // Backpressure holds the candidate
    do_reset();
    issue_ready = 0;
    launch(1);
    g = 0;
    while (!m_iv && g < 5) begin step(); g++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", issue_valid, 1);
      chk("bp_id", issue_warp_id, 0);
      chk("bp_pc", issue_pc, 0);
      step();
    end
    issue_ready = 1;
    step();
    issue_ready = 0;
    @(negedge clk);
    chk("bp_bubble", issue_valid, 0);

    // Completion with all four warps returning
    do_reset();
    auto_mode = 2; issue_ready = 1;
    launch(4);
    g = 0;
    while (ret_cnt < 4 && g < 60) begin step(); g++; end
    chk("ret_all_driven", ret_cnt, 4);
    while (cyc < last_edge) step();
    @(negedge clk);
    chk("done_not_early", done, 0);
    step();
    @(negedge clk);
    chk("done_on_time", done, 1);
    warp_count = 2; start = 1;
    repeat (4) step();
    @(negedge clk);
    chk("done_holds", done, 1);
    chk("done_no_issue", issue_valid, 0);

    // Zero warps launched
    do_reset();
    launch(0);
    @(negedge clk);
    chk("zero_done_launch_edge", done, 0);
    step();
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_no_issue", issue_valid, 0);

    // Retire aimed at a ready warp
    do_reset();
    launch(2);
    retire_valid = 1; retire_warp_id = 1; retire_next_pc = 7;
    step();
    @(negedge clk);
    chk("bad_retire_err", protocol_err, 1);
    issue_ready = 1;
    step();
    issue_ready = 0;
    step();
    @(negedge clk);
    chk("bad_retire_id", issue_warp_id, 1);
    chk("bad_retire_pc", issue_pc, 0);
    chk("bad_retire_valid", issue_valid, 1);

    // Reset while warps are in flight and stalled
    do_reset();
    auto_mode = 1; issue_ready = 1; mw_armed = 1; mw_warp = 0; mw_pc = 9;
    launch(2);
    repeat (8) step();
    reset = 0;
    step();
    reset = 1; auto_mode = 0; issue_ready = 0;
    @(negedge clk);
    chk("midrst_valid", issue_valid, 0);
    chk("midrst_id", issue_warp_id, 0);
    chk("midrst_pc", issue_pc, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", protocol_err, 0);
    launch(1);
    g = 0;
    while (!issue_valid && g < 5) begin step(); g++; end
    @(negedge clk);
    chk("relaunch_valid", issue_valid, 1);
    chk("relaunch_id", issue_warp_id, 0);
    chk("relaunch_pc", issue_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
